// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder windows.
package mem_pkg;

  // Responder FSM: accepting, counting down latency, holding a response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bytes per memory word; addresses are byte addresses, the array is word indexed.
  localparam int WORD_BYTES = 4;

  // Width of the latency down-counter; holds LATENCY-1 for LATENCY up to 15.
  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational window decode: is a byte address inside this window and
// word aligned, and which word of the window does it select.
module mem_addr_decode
  import mem_pkg::*;
#(
  parameter int WORD_DEPTH = 36,
  parameter int IDX_W      = 6
) (
  input  logic [31:0]      addr,
  input  logic [31:0]      offset,
  output logic             in_range,
  output logic [IDX_W-1:0] index
);

  localparam logic [32:0] SPAN = 33'(WORD_DEPTH * WORD_BYTES);

  logic [31:0] diff;

  // Bound check on the distance from the base: once addr >= offset the
  // subtraction cannot wrap, and comparing the distance against the window
  // size is the same as addr < offset + size done in 33 bits, so a window
  // whose end passes 2^32 simply runs to 0xFFFFFFFF.
  always_comb begin
    diff     = addr - offset;
    in_range = (addr >= offset) && ({1'b0, diff} < SPAN) && (addr[1:0] == 2'b00);
    index    = diff[IDX_W+1:2];
  end

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory window with a request/response handshake and a
// fixed, programmable response latency.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; a response is consumed on a rising edge where
// resp_valid and resp_ready are both 1. req_ready is 1 only in IDLE, so a
// single request is outstanding at a time, and resp_valid/resp_rdata/resp_err
// stay frozen from the moment resp_valid rises until the response is taken.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WORD_DEPTH = 36,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] offset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int             IDX_W    = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);
  localparam bit             LAT_ONE  = (LATENCY == 1);

  // Not reset; preloaded hierarchically or filled by writes.
  logic [31:0] mem [WORD_DEPTH];

  // Current FSM state, kept as a plain named variable so checkers can bind to it.
  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic               in_range;
  logic [IDX_W-1:0]   index;
  logic               accept;

  // Reset wins over a simultaneous request.
  assign accept = req_valid && req_ready && !rst;

  mem_addr_decode #(
    .WORD_DEPTH (WORD_DEPTH),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr     (req_addr),
    .offset   (offset),
    .in_range (in_range),
    .index    (index)
  );

  // Writes commit at the accept edge, so a later reset cannot undo them.
  always_ff @(posedge clk) begin
    if (accept && req_wen && in_range) begin
      mem[index] <= req_wdata;
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            // Read data is captured now; later req_*/offset changes are ignored.
            resp_err   <= !in_range;
            resp_rdata <= (in_range && !req_wen) ? mem[index] : '0;
            req_ready  <= 1'b0;
            if (LAT_ONE) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              lat_cnt    <= '0;
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_LOAD;
            end
          end
        end
        WAIT: begin
          // The counter reaching 0 on this edge means resp_valid rises
          // exactly LATENCY cycles after the accept cycle.
          if (lat_cnt <= LAT_W'(1)) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            lat_cnt    <= '0;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
